// File: rtl/sync_pkg.sv
// Shared constants and elaboration-time helpers for the filtered synchronizer.
package sync_pkg;

  localparam int SYNC_MIN_DEPTH = 2;
  localparam int SYNC_MAX_DEPTH = 8;
  localparam int FILT_MAX       = 65535;

  // Bits needed to represent values 0..value-1, never less than one bit.
  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  function automatic int clamp_depth(input int depth);
    if (depth < SYNC_MIN_DEPTH) return SYNC_MIN_DEPTH;
    if (depth > SYNC_MAX_DEPTH) return SYNC_MAX_DEPTH;
    return depth;
  endfunction

  function automatic int clamp_filt(input int cycles);
    if (cycles < 0) return 0;
    if (cycles > FILT_MAX) return FILT_MAX;
    return cycles;
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel of stability filtering: accepts a new level only after it has
// persisted for FILT consecutive cycles, and emits registered rise/fall strobes.
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int   FILT      = 0,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int CW = clogb2(FILT + 1);
  localparam logic [CW-1:0] LAST = (FILT == 0) ? '0 : CW'(FILT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] next_cnt;
  logic          next_dout;

  // Acceptance is tested before the increment, so the counter never wraps.
  always_comb begin
    next_dout = dout;
    next_cnt  = '0;
    if (FILT == 0) begin
      next_dout = s;
    end else if (s == dout) begin
      next_cnt = '0;
    end else if (cnt == LAST) begin
      next_dout = s;
      next_cnt  = '0;
    end else begin
      next_cnt = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      dout <= RESET_BIT;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt  <= next_cnt;
      dout <= next_dout;
      rise <= ~dout & next_dout;
      fall <= dout & ~next_dout;
    end
  end

endmodule

// File: rtl/sync_filtered.sv
// Multi-bit incoherent synchronizer: a flop chain per bit followed by an
// independent deglitch filter and edge strobes on every channel.
module sync_filtered
  import sync_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               DEPTH         = 2,
  parameter int               FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int SYNC_DEPTH = clamp_depth(DEPTH);
  localparam int FILT       = clamp_filt(FILTER_CYCLES);

  logic [WIDTH-1:0] stage [SYNC_DEPTH];

  // Pure flop chain: nothing may sit between stages or metastability
  // resolution time is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_DEPTH; k++) stage[k] <= RESET_VAL;
    end else begin
      stage[0] <= din;
      for (int k = 1; k < SYNC_DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sync_filter_chan #(
      .FILT      (FILT),
      .RESET_BIT (RESET_VAL[i])
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .s    (stage[SYNC_DEPTH-1][i]),
      .dout (dout[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

endmodule

// File: tb/tb_sync_filtered.sv
// Directed checks of sync_filtered: reset, filter acceptance/rejection, edge
// strobes, bypassed filter and depth clamping.
module tb_sync_filtered;

  logic clk;
  logic rst;
  logic [3:0] din_main;
  logic [3:0] dout_main, rise_main, fall_main;
  logic din_nf, dout_nf, rise_nf, fall_nf;
  logic din_d1, dout_d1, rise_d1, fall_d1;
  logic din_d12, dout_d12, rise_d12, fall_d12;

  int checks = 0;
  int errors = 0;

  sync_filtered #(.WIDTH(4), .DEPTH(3), .FILTER_CYCLES(4), .RESET_VAL(4'b0101)) u_main (
    .clk(clk), .rst(rst), .din(din_main), .dout(dout_main), .rise(rise_main), .fall(fall_main));

  sync_filtered #(.WIDTH(1), .DEPTH(3), .FILTER_CYCLES(0), .RESET_VAL(1'b0)) u_nf (
    .clk(clk), .rst(rst), .din(din_nf), .dout(dout_nf), .rise(rise_nf), .fall(fall_nf));

  sync_filtered #(.WIDTH(1), .DEPTH(1), .FILTER_CYCLES(4), .RESET_VAL(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .din(din_d1), .dout(dout_d1), .rise(rise_d1), .fall(fall_d1));

  sync_filtered #(.WIDTH(1), .DEPTH(12), .FILTER_CYCLES(4), .RESET_VAL(1'b0)) u_d12 (
    .clk(clk), .rst(rst), .din(din_d12), .dout(dout_d12), .rise(rise_d12), .fall(fall_d12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] value);
    din_main = value;
  endtask

  // Advance n active edges and land 1 time unit past the last one.
  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [3:0] d, input logic [3:0] r, input logic [3:0] f);
    checkOutput({tag, "_dout"}, dout_main, d);
    checkOutput({tag, "_rise"}, rise_main, r);
    checkOutput({tag, "_fall"}, fall_main, f);
  endtask

  initial begin
    rst = 1'b0;
    din_main = 4'b0101;
    din_nf = 1'b0;
    din_d1 = 1'b0;
    din_d12 = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_main("por", 4'b0101, 4'b0000, 4'b0000);
    checkOutput("por_nf", {3'b0, dout_nf}, 4'b0000);

    step_cycles(2);
    rst = 1'b0;

    // Drive everything high so dout reaches 1111 before the mid-cycle reset.
    applyStimulus(4'b1111);
    step_cycles(7);
    check_main("all_high", 4'b1111, 4'b1010, 4'b0000);
    #3 rst = 1'b1;
    #1;
    check_main("async_rst", 4'b0101, 4'b0000, 4'b0000);
    applyStimulus(4'b0101);
    step_cycles(2);
    check_main("in_rst", 4'b0101, 4'b0000, 4'b0000);
    rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      step_cycles(1);
      check_main("post_rst", 4'b0101, 4'b0000, 4'b0000);
    end

    // din[1] rises and is held: visible after edge 3 + 4.
    applyStimulus(4'b0111);
    step_cycles(6);
    check_main("b1_pre", 4'b0101, 4'b0000, 4'b0000);
    step_cycles(1);
    check_main("b1_edge", 4'b0111, 4'b0010, 4'b0000);
    step_cycles(1);
    check_main("b1_after", 4'b0111, 4'b0000, 4'b0000);

    // Three-cycle glitch on din[3] must be rejected entirely.
    applyStimulus(4'b1111);
    step_cycles(3);
    applyStimulus(4'b0111);
    for (int c = 0; c < 12; c++) begin
      check_main("glitch3", 4'b0111, 4'b0000, 4'b0000);
      step_cycles(1);
    end

    // Four-cycle pulse is accepted, and the fall follows four cycles later.
    applyStimulus(4'b1111);
    step_cycles(4);
    applyStimulus(4'b0111);
    step_cycles(2);
    check_main("pulse4_pre", 4'b0111, 4'b0000, 4'b0000);
    step_cycles(1);
    check_main("pulse4_rise", 4'b1111, 4'b1000, 4'b0000);
    step_cycles(3);
    check_main("pulse4_hold", 4'b1111, 4'b0000, 4'b0000);
    step_cycles(1);
    check_main("pulse4_fall", 4'b0111, 4'b0000, 4'b1000);
    step_cycles(1);
    check_main("pulse4_after", 4'b0111, 4'b0000, 4'b0000);

    applyStimulus(4'b0101);
    step_cycles(7);
    check_main("b1_fall", 4'b0101, 4'b0000, 4'b0010);
    step_cycles(1);

    // All four channels flip on the same cycle.
    applyStimulus(4'b1010);
    step_cycles(6);
    check_main("flip_pre", 4'b0101, 4'b0000, 4'b0000);
    step_cycles(1);
    check_main("flip", 4'b1010, 4'b1010, 4'b0101);
    step_cycles(1);
    check_main("flip_after", 4'b1010, 4'b0000, 4'b0000);

    // Filter bypassed: latency 3 + 1 edges, single-cycle pulses pass through.
    din_nf = 1'b1;
    step_cycles(3);
    checkOutput("nf_pre", {1'b0, dout_nf, rise_nf, fall_nf}, 4'b0000);
    step_cycles(1);
    checkOutput("nf_rise", {1'b0, dout_nf, rise_nf, fall_nf}, 4'b0110);
    step_cycles(1);
    checkOutput("nf_hold", {1'b0, dout_nf, rise_nf, fall_nf}, 4'b0100);
    din_nf = 1'b0;
    step_cycles(1);
    din_nf = 1'b1;
    step_cycles(2);
    checkOutput("nf_pulse_pre", {1'b0, dout_nf, rise_nf, fall_nf}, 4'b0100);
    step_cycles(1);
    checkOutput("nf_pulse_fall", {1'b0, dout_nf, rise_nf, fall_nf}, 4'b0001);
    step_cycles(1);
    checkOutput("nf_pulse_rise", {1'b0, dout_nf, rise_nf, fall_nf}, 4'b0110);
    step_cycles(1);
    checkOutput("nf_pulse_after", {1'b0, dout_nf, rise_nf, fall_nf}, 4'b0100);

    // DEPTH=1 clamps to 2 stages: 2 + 4 edges.
    din_d1 = 1'b1;
    step_cycles(5);
    checkOutput("d1_pre", {1'b0, dout_d1, rise_d1, fall_d1}, 4'b0000);
    step_cycles(1);
    checkOutput("d1_rise", {1'b0, dout_d1, rise_d1, fall_d1}, 4'b0110);

    // DEPTH=12 clamps to 8 stages: 8 + 4 edges.
    din_d12 = 1'b1;
    step_cycles(11);
    checkOutput("d12_pre", {1'b0, dout_d12, rise_d12, fall_d12}, 4'b0000);
    step_cycles(1);
    checkOutput("d12_rise", {1'b0, dout_d12, rise_d12, fall_d12}, 4'b0110);
    step_cycles(1);
    checkOutput("d12_after", {1'b0, dout_d12, rise_d12, fall_d12}, 4'b0100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
